// File: rtl/uart_transmitter_if.sv
// Byte handshake between a producer and the UART transmitter.
// Latency: none, signal bundle only.
// Backpressure: producer holds data_in_valid until it sees data_in_ready.
interface uart_transmitter_if;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;

  // Producer side: offers bytes and watches ready.
  modport master (
    output data_in,
    output data_in_valid,
    input  data_in_ready
  );

  // Transmitter side: consumes bytes and drives ready.
  modport slave (
    input  data_in,
    input  data_in_valid,
    output data_in_ready
  );
endinterface

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter, LSB first, idle-high line; optional even parity via UART_TX_PARITY_EN.
// Latency: start bit on the line the cycle after the accept edge; frame is 10*N (11*N with parity) cycles.
// Backpressure: data_in_ready is high only in IDLE; a held valid is taken on the first IDLE edge.
module uart_transmitter #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic                clk,
  input  logic                rst,
  uart_transmitter_if.slave   bus,
  output logic                serial_out
);

  localparam int SYMBOL_EDGE_TIME    = CLOCK_FREQ / BAUD_RATE;
  localparam int CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME);
  localparam logic [CLOCK_COUNTER_WIDTH-1:0] LAST_CNT =
    CLOCK_COUNTER_WIDTH'(SYMBOL_EDGE_TIME - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                         r_state;
  logic [CLOCK_COUNTER_WIDTH-1:0] r_clk_cnt;
  logic [2:0]                     r_bit_idx;
  logic [7:0]                     r_shift;
  logic                           r_serial;
  logic                           r_ready;
  logic                           w_bit_done;
  logic [2:0]                     w_next_idx;

  assign w_bit_done         = (r_clk_cnt == LAST_CNT);
  assign w_next_idx         = r_bit_idx + 3'd1;
  assign serial_out         = r_serial;
  assign bus.data_in_ready  = r_ready;

  // Frame sequencer: every output is a register, so the line never glitches.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_serial  <= 1'b1;
      r_ready   <= 1'b1;
    end else begin
      // Symbol timer runs in every busy state and wraps at each bit boundary.
      if (r_state == IDLE || w_bit_done) begin
        r_clk_cnt <= '0;
      end else begin
        r_clk_cnt <= r_clk_cnt + 1'b1;
      end

      case (r_state)
        IDLE: begin
          r_bit_idx <= '0;
          r_serial  <= 1'b1;
          r_ready   <= 1'b1;
          if (bus.data_in_valid && r_ready) begin
            r_shift  <= bus.data_in;
            r_serial <= 1'b0;
            r_ready  <= 1'b0;
            r_state  <= START;
          end
        end
        START: begin
          if (w_bit_done) begin
            r_serial  <= r_shift[0];
            r_bit_idx <= '0;
            r_state   <= DATA;
          end
        end
        DATA: begin
          if (w_bit_done) begin
            if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_serial <= ^r_shift;
              r_state  <= PARITY;
`else
              r_serial <= 1'b1;
              r_state  <= STOP;
`endif
            end else begin
              r_serial  <= r_shift[w_next_idx];
              r_bit_idx <= w_next_idx;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_bit_done) begin
            r_serial <= 1'b1;
            r_state  <= STOP;
          end
        end
`endif
        STOP: begin
          if (w_bit_done) begin
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: begin
          r_serial <= 1'b1;
          r_ready  <= 1'b1;
          r_state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at 50 MHz / 115200 baud (N = 434).
// Latency: samples 1 time unit after each rising edge; cycle 1 is the cycle after the accept edge.
// Backpressure: exercises held valid while busy and back-to-back frames.
module tb_uart_transmitter;

  localparam int N = 434;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic clk;
  logic rst;
  logic serial_out;
  int   checks;
  int   errors;

  uart_transmitter_if bus_if ();

  uart_transmitter #(
    .CLOCK_FREQ(50_000_000),
    .BAUD_RATE (115_200)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .serial_out(serial_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and land just after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called in cycle 1 of a frame; records mid-bit line values and ready
  // behaviour, and returns in cycle NBITS*N+1.
  task automatic capture_frame(output logic [10:0] bits, output int ready_high_busy,
                               output logic ready_at_end);
    bits = '0;
    ready_high_busy = 0;
    ready_at_end = 1'b0;
    for (int c = 1; c <= NBITS * N + 1; c++) begin
      if (c > 1) tick(1);
      for (int k = 0; k < NBITS; k++) begin
        if (c == k * N + N / 2) bits[k] = serial_out;
      end
      if (c <= NBITS * N && bus_if.data_in_ready) ready_high_busy++;
      if (c == NBITS * N + 1) ready_at_end = bus_if.data_in_ready;
    end
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b0;
    bus_if.data_in_valid = 1'b0;
    bus_if.data_in = 8'h00;
    tick(10);
    checks++;
    if (serial_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_serial: got %b want 1", serial_out);
    end
    checks++;
    if (bus_if.data_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", bus_if.data_in_ready);
    end
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 5000; i++) begin
      tick(1);
      if (serial_out !== 1'b1 || bus_if.data_in_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL reset_idle_hold: %0d bad cycles, want 0", bad);
    end
  endtask

  task automatic test_single_byte();
    logic [10:0] bits;
    int          busy_hi;
    logic        rdy;
`ifdef UART_TX_PARITY_EN
    logic exp_bits [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
    logic exp_bits [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif
    bus_if.data_in = 8'hA5;
    bus_if.data_in_valid = 1'b1;
    tick(1);
    bus_if.data_in_valid = 1'b0;
    capture_frame(bits, busy_hi, rdy);
    for (int k = 0; k < NBITS; k++) begin
      checks++;
      if (bits[k] !== exp_bits[k]) begin
        errors++;
        $display("FAIL a5_bit%0d: got %b want %b", k, bits[k], exp_bits[k]);
      end
    end
    checks++;
    if (busy_hi !== 0) begin
      errors++;
      $display("FAIL a5_ready_low: ready high in %0d busy cycles, want 0", busy_hi);
    end
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL a5_ready_rise: got %b at cycle %0d want 1", rdy, NBITS * N + 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] b0, b1;
    int          busy_hi;
    logic        rdy;
    bus_if.data_in = 8'h00;
    bus_if.data_in_valid = 1'b1;
    tick(1);
    bus_if.data_in = 8'hFF;
    capture_frame(b0, busy_hi, rdy);
    checks++;
    if (serial_out !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap_idle: got %b want 1", serial_out);
    end
    tick(1);
    checks++;
    if (serial_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_start: got %b at cycle %0d want 0", serial_out, NBITS * N + 2);
    end
    bus_if.data_in_valid = 1'b0;
    capture_frame(b1, busy_hi, rdy);
    checks++;
    if (b0[8:1] !== 8'h00) begin
      errors++;
      $display("FAIL b2b_byte0: got %h want 00", b0[8:1]);
    end
    checks++;
    if (b1[8:1] !== 8'hFF) begin
      errors++;
      $display("FAIL b2b_byte1: got %h want ff", b1[8:1]);
    end
  endtask

  task automatic test_data_stability();
    logic [10:0] bits;
    int          busy_hi;
    logic        rdy;
    tick(3);
    bus_if.data_in = 8'h81;
    bus_if.data_in_valid = 1'b1;
    tick(1);
    bus_if.data_in = 8'h3C;
    bus_if.data_in_valid = 1'b0;
    capture_frame(bits, busy_hi, rdy);
    checks++;
    if (bits[8:1] !== 8'h81) begin
      errors++;
      $display("FAIL stability_byte: got %h want 81", bits[8:1]);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] bits;
    int          busy_hi;
    logic        rdy;
    tick(3);
    bus_if.data_in = 8'h00;
    bus_if.data_in_valid = 1'b1;
    tick(1);
    bus_if.data_in_valid = 1'b0;
    tick(4 * N + N / 2 - 1);
    checks++;
    if (serial_out !== 1'b0) begin
      errors++;
      $display("FAIL midrst_bit3_before: got %b want 0", serial_out);
    end
    rst = 1'b0;
    tick(1);
    checks++;
    if (serial_out !== 1'b1) begin
      errors++;
      $display("FAIL midrst_serial: got %b want 1", serial_out);
    end
    checks++;
    if (bus_if.data_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ready: got %b want 1", bus_if.data_in_ready);
    end
    rst = 1'b1;
    bus_if.data_in = 8'h55;
    bus_if.data_in_valid = 1'b1;
    tick(1);
    bus_if.data_in_valid = 1'b0;
    capture_frame(bits, busy_hi, rdy);
    checks++;
    if (bits[8:1] !== 8'h55) begin
      errors++;
      $display("FAIL midrst_new_byte: got %h want 55", bits[8:1]);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [10:0] bits;
    int          busy_hi;
    logic        rdy;
    tick(3);
    bus_if.data_in = 8'h07;
    bus_if.data_in_valid = 1'b1;
    tick(1);
    bus_if.data_in_valid = 1'b0;
    capture_frame(bits, busy_hi, rdy);
    checks++;
    if (bits[9] !== 1'b1) begin
      errors++;
      $display("FAIL parity_07: got %b want 1", bits[9]);
    end
    checks++;
    if (bits[10] !== 1'b1) begin
      errors++;
      $display("FAIL parity_07_stop: got %b want 1", bits[10]);
    end
    checks++;
    if (rdy !== 1'b1 || busy_hi !== 0) begin
      errors++;
      $display("FAIL parity_ready_4775: ready=%b busy_high=%0d want 1/0", rdy, busy_hi);
    end
    tick(3);
    bus_if.data_in = 8'h03;
    bus_if.data_in_valid = 1'b1;
    tick(1);
    bus_if.data_in_valid = 1'b0;
    capture_frame(bits, busy_hi, rdy);
    checks++;
    if (bits[9] !== 1'b0) begin
      errors++;
      $display("FAIL parity_03: got %b want 0", bits[9]);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus_if.data_in = 8'h00;
    bus_if.data_in_valid = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_data_stability();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
